// File: rtl/alu_arbiter_if.sv
// Shared operation-select type and the requester/response/ALU bus
// between the arbiter and its environment.
package Types;
    typedef logic [3:0] sel_t;
endpackage

interface alu_arbiter_if;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [7:0]          req_op1;
    logic [7:0]          req_op2;
    Types::sel_t [1:0]   req_sel;
    logic [1:0]          req_cin;
    logic [1:0]          req_mode;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [7:0]          rsp_result;
    logic                rsp_equal;
    logic [3:0]          alu_op1;
    logic [3:0]          alu_op2;
    Types::sel_t         alu_sel;
    logic                alu_cin;
    logic                alu_mode;
    logic [7:0]          alu_result;
    logic                alu_equal;

    modport master (
        output req_valid, req_op1, req_op2, req_sel, req_cin, req_mode,
        output rsp_ready, alu_result, alu_equal,
        input  req_ready, rsp_valid, rsp_result, rsp_equal,
        input  alu_op1, alu_op2, alu_sel, alu_cin, alu_mode
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_sel, req_cin, req_mode,
        input  rsp_ready, alu_result, alu_equal,
        output req_ready, rsp_valid, rsp_result, rsp_equal,
        output alu_op1, alu_op2, alu_sel, alu_cin, alu_mode
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU,
// one transaction in flight, response held until accepted.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstb,
    alu_arbiter_if.slave     bus,
    output logic             busy_o,
    output logic             grant_id_o,
    output logic [CNT_W-1:0] op_count_o
);
    import Types::*;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, grant_q;
    logic [3:0]       op1_q, op2_q;
    sel_t             sel_q;
    logic             cin_q, mode_q;
    logic [2:0]       wait_q;
    logic [7:0]       res_q;
    logic             eq_q;
    logic [CNT_W-1:0] cnt_q;

    logic win, req_hs, exec_done, rsp_hs;

    // ptr owner first, otherwise the other requester
    assign win       = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
    assign req_hs    = (state_q == IDLE) && (|bus.req_valid);
    assign exec_done = (state_q == EXEC) && (wait_q == 3'd0);
    assign rsp_hs    = (state_q == RESP) && bus.rsp_ready[grant_q];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_hs)    state_d = EXEC;
            EXEC:    if (exec_done) state_d = RESP;
            RESP:    if (rsp_hs)    state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        busy_o        = (state_q != IDLE);
        if (rstb && req_hs)
            bus.req_ready = win ? 2'b10 : 2'b01;
        if (state_q == RESP)
            bus.rsp_valid = grant_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            mode_q  <= 1'b0;
            wait_q  <= '0;
            res_q   <= '0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (req_hs) begin
                grant_q <= win;
                op1_q   <= win ? bus.req_op1[7:4] : bus.req_op1[3:0];
                op2_q   <= win ? bus.req_op2[7:4] : bus.req_op2[3:0];
                sel_q   <= bus.req_sel[win];
                cin_q   <= bus.req_cin[win];
                mode_q  <= bus.req_mode[win];
                wait_q  <= 3'(ALU_LAT - 1);
            end else if (state_q == EXEC && !exec_done) begin
                wait_q  <= wait_q - 3'd1;
            end
            if (exec_done) begin
                res_q <= bus.alu_result;
                eq_q  <= bus.alu_equal;
            end
            if (rsp_hs) begin
                cnt_q <= cnt_q + 1'b1;
                ptr_q <= ~grant_q;
            end
        end
    end

    assign bus.alu_op1    = op1_q;
    assign bus.alu_op2    = op2_q;
    assign bus.alu_sel    = sel_q;
    assign bus.alu_cin    = cin_q;
    assign bus.alu_mode   = mode_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_equal  = eq_q;
    assign grant_id_o     = grant_q;
    assign op_count_o     = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: dut A (ALU_LAT=1, CNT_W=4) and dut B (ALU_LAT=3)
// sharing clock and reset, each with a small ALU model.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rstb;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_arbiter_if ia();
    alu_arbiter_if ib();

    logic       busy_a, gid_a, busy_b, gid_b;
    logic [3:0] cnt_a;
    logic [15:0] cnt_b;

    alu_arbiter #(.ALU_LAT(1), .CNT_W(4)) dut_a (
        .clk(clk), .rstb(rstb), .bus(ia.slave),
        .busy_o(busy_a), .grant_id_o(gid_a), .op_count_o(cnt_a)
    );

    alu_arbiter #(.ALU_LAT(3)) dut_b (
        .clk(clk), .rstb(rstb), .bus(ib.slave),
        .busy_o(busy_b), .grant_id_o(gid_b), .op_count_o(cnt_b)
    );

    // add with carry, XOR for nonzero sel, concat in mode 1
    assign ia.alu_result = ia.alu_mode ? {ia.alu_op1, ia.alu_op2} :
        (ia.alu_sel == 4'd0) ?
        ({4'd0, ia.alu_op1} + {4'd0, ia.alu_op2} + {7'd0, ia.alu_cin}) :
        {4'd0, ia.alu_op1 ^ ia.alu_op2};
    assign ia.alu_equal  = (ia.alu_op1 == ia.alu_op2);
    assign ib.alu_result = ib.alu_mode ? {ib.alu_op1, ib.alu_op2} :
        (ib.alu_sel == 4'd0) ?
        ({4'd0, ib.alu_op1} + {4'd0, ib.alu_op2} + {7'd0, ib.alu_cin}) :
        {4'd0, ib.alu_op1 ^ ib.alu_op2};
    assign ib.alu_equal  = (ib.alu_op1 == ib.alu_op2);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstb = 1'b0;
        ia.req_valid = '0; ia.req_op1 = '0; ia.req_op2 = '0;
        ia.req_sel = '0; ia.req_cin = '0; ia.req_mode = '0;
        ia.rsp_ready = '0;
        ib.req_valid = '0; ib.req_op1 = '0; ib.req_op2 = '0;
        ib.req_sel = '0; ib.req_cin = '0; ib.req_mode = '0;
        ib.rsp_ready = '0;
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_ready", 32'(ia.req_ready), 0);
        chk("rst_rspv", 32'(ia.rsp_valid), 0);
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_gid", 32'(gid_a), 0);
        chk("rst_op1", 32'(ia.alu_op1), 0);
        chk("rst_res", 32'(ia.rsp_result), 0);
        #2 rstb = 1'b1;
        tick; tick;

        // valid dropped before grant
        ia.req_valid = 2'b01;
        #1 chk("drop_ready", 32'(ia.req_ready), 32'h1);
        ia.req_valid = 2'b00;
        #1 chk("drop_ready0", 32'(ia.req_ready), 0);
        tick;
        chk("drop_busy", 32'(busy_a), 0);

        // single req0: 1+1+0 = 2, equal
        ia.req_op1 = 8'h51; ia.req_op2 = 8'h31; ia.req_cin = 2'b10;
        ia.rsp_ready = 2'b01; ia.req_valid = 2'b01;
        #1 chk("r0_ready", 32'(ia.req_ready), 32'h1);
        tick;
        chk("r0_busy", 32'(busy_a), 1);
        chk("r0_ready_exec", 32'(ia.req_ready), 0);
        chk("r0_aluop1", 32'(ia.alu_op1), 1);
        chk("r0_rspv_exec", 32'(ia.rsp_valid), 0);
        ia.req_valid = 2'b00;
        tick;
        chk("r0_rspv", 32'(ia.rsp_valid), 32'h1);
        chk("r0_res", 32'(ia.rsp_result), 32'h02);
        chk("r0_eq", 32'(ia.rsp_equal), 1);
        chk("r0_gid", 32'(gid_a), 0);
        tick;
        chk("r0_cnt", 32'(cnt_a), 1);
        chk("r0_idle", 32'(busy_a), 0);

        // req1 with stalled response: 5+3+1 = 9, not equal
        ia.rsp_ready = 2'b00; ia.req_valid = 2'b10;
        #1 chk("r1_ready", 32'(ia.req_ready), 32'h2);
        tick; tick;
        ia.req_valid = 2'b01;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rspv", 32'(ia.rsp_valid), 32'h2);
            chk("stall_res", 32'(ia.rsp_result), 32'h09);
            chk("stall_ready", 32'(ia.req_ready), 0);
            chk("stall_cnt", 32'(cnt_a), 1);
            tick;
        end
        ia.rsp_ready = 2'b01;
        tick;
        chk("nonowner_rspv", 32'(ia.rsp_valid), 32'h2);
        chk("nonowner_cnt", 32'(cnt_a), 1);
        ia.rsp_ready = 2'b10;
        tick;
        chk("r1_cnt", 32'(cnt_a), 2);
        chk("r1_eq", 32'(ia.rsp_equal), 0);
        chk("r1_nextready", 32'(ia.req_ready), 32'h1);

        // contention: alternation 0,1,0,1 and counter wrap at 16
        ia.req_valid = 2'b11; ia.rsp_ready = 2'b11;
        for (int k = 3; k <= 17; k++) begin
            #1;
            chk("alt_ready", 32'(ia.req_ready), (k % 2) ? 32'h1 : 32'h2);
            chk("alt_idle", 32'(busy_a), 0);
            tick;
            chk("alt_busy", 32'(busy_a), 1);
            chk("alt_noready", 32'(ia.req_ready), 0);
            tick;
            chk("alt_rspv", 32'(ia.rsp_valid), (k % 2) ? 32'h1 : 32'h2);
            tick;
            chk("alt_cnt", 32'(cnt_a), 32'(k % 16));
        end
        ia.req_valid = 2'b00; ia.rsp_ready = 2'b00;

        // dut B, ALU_LAT=3: 7+7 = 0x0e, equal, response at N+4
        ib.req_op1 = 8'h07; ib.req_op2 = 8'h07;
        ib.rsp_ready = 2'b01; ib.req_valid = 2'b01;
        #1 chk("b_ready", 32'(ib.req_ready), 32'h1);
        tick;
        ib.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk("b_exec_busy", 32'(busy_b), 1);
            chk("b_exec_rspv", 32'(ib.rsp_valid), 0);
            chk("b_exec_op1", 32'(ib.alu_op1), 7);
            chk("b_exec_op2", 32'(ib.alu_op2), 7);
            tick;
        end
        chk("b_rspv", 32'(ib.rsp_valid), 32'h1);
        chk("b_res", 32'(ib.rsp_result), 32'h0e);
        chk("b_eq", 32'(ib.rsp_equal), 1);
        tick;
        chk("b_cnt", 32'(cnt_b), 1);

        // reset asserted mid-EXEC
        ia.req_op1 = 8'h0f; ia.rsp_ready = 2'b01; ia.req_valid = 2'b01;
        tick;
        chk("ar_busy", 32'(busy_a), 1);
        #2 rstb = 1'b0;
        #1;
        chk("ar_rst_busy", 32'(busy_a), 0);
        chk("ar_rst_ready", 32'(ia.req_ready), 0);
        chk("ar_rst_rspv", 32'(ia.rsp_valid), 0);
        chk("ar_rst_cnt", 32'(cnt_a), 0);
        chk("ar_rst_op1", 32'(ia.alu_op1), 0);
        chk("ar_rst_gid", 32'(gid_a), 0);
        ia.req_valid = 2'b00;
        #1 rstb = 1'b1;
        tick; tick; tick;
        chk("ar_post_rspv", 32'(ia.rsp_valid), 0);
        chk("ar_post_busy", 32'(busy_a), 0);
        chk("ar_post_cnt", 32'(cnt_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
